uart_rx_mmio: RTL and testbench
===============================

Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver for the NoobsCPU SoC; the receive-side counterpart of the UART TX peripheral.
- Oversamples the serial RX pin 16x, deframes 8N1 characters, and buffers them in a small FIFO.
- Presents data and status registers on the CPU data bus (m_addr/m_rd/m_wr/m_en).
- The SoC read mux selects rd_data whenever rd_hit is high.

Parameters:
- SAMPLE_DIV, 13, clk cycles per 16x oversample tick (12 MHz / 16 / 13 ≈ 57692 baud); legal range 1..255.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, range 2..16.
- DATA_ADDR, 11'd102, CPU address of the RX data register (read pops).
- STAT_ADDR, 11'd103, CPU address of the RX status register.

Ports:
- clk  in  1  system/CPU clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- m_addr  in  11  CPU data address
- m_rd  in  1  CPU read strobe
- m_wr  in  1  CPU write strobe
- m_en  in  1  CPU data-bus enable
- m_wr_data  in  8  CPU write data
- rd_data  out  8  register read data (combinational)
- rd_hit  out  1  high when a read targets DATA_ADDR or STAT_ADDR
- irq  out  1  high while the FIFO is non-empty

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Reset asserted forces: FSM=IDLE, FIFO empty, sticky flags 0, tick counter 0, synchroniser flops 1.
  - Outputs under reset: irq=0, rd_hit follows bus decode, rd_data=0x00.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Synchroniser: rx passes through 2 flops (rx_s). Edge detection uses rx_s and its 1-cycle delayed copy.
- Tick generator: a counter wraps at SAMPLE_DIV-1 and pulses tick for 1 cycle. It free-runs in all states except IDLE, where it is held at 0.
- FSM (advances only on tick, except the IDLE exit):
  - IDLE: rx_s falling edge -> START, sample count sc=0.
  - START: at sc=7, rx_s=0 -> DATA (bit index 0, sc=0). rx_s=1 is a glitch -> IDLE, nothing recorded.
  - DATA: at sc=15, shift rx_s into the shift register LSB-first. After bit 7 -> STOP.
  - STOP: at sc=15, evaluate the stop bit:
    - rx_s=1: push the byte, or set ovr if the FIFO is full (new byte dropped, FIFO unchanged); -> IDLE.
    - rx_s=0: set ferr, drop the byte -> BRK.
  - BRK: wait for rx_s=1 (sampled every clk), then -> IDLE. This prevents a held-low line from retriggering.
- sc is 4 bits and wraps 15->0.
- Bus decode: rd_sel = m_en & m_rd; wr_sel = m_en & m_wr.
  - rd_hit = rd_sel & (m_addr==DATA_ADDR | m_addr==STAT_ADDR).
- DATA_ADDR read:
  - rd_data = FIFO head; the pop happens on the same clk edge.
  - Empty FIFO: rd_data=0x00, no pop, no flag change.
- STAT_ADDR read: rd_data = {4'b0, ferr, ovr, full, ~empty}. Reading has no side effect.
- STAT_ADDR write (any data) clears ovr and ferr. Writes to DATA_ADDR are ignored.
- Simultaneous push and pop in one cycle:
  - Both occur; occupancy is unchanged.
  - When full, this is NOT an overrun; the new byte is accepted.
  - When empty, the pop is suppressed and rd_data=0x00.
- Simultaneous ovr/ferr set and status-write clear: set wins.
- Pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit.
  - full = ptrs equal except the MSB.
  - empty = ptrs fully equal.
- Latency: a byte is readable on the clk after the STOP mid-sample tick. irq rises in the same cycle.
- Unselected cycles: rd_data=0x00.

Decomposition:
- Shared include uart_defs.vh holds:
  - DATA_ADDR and STAT_ADDR defaults, next to the existing LED and UART TX address defines.
  - Status bit positions (ST_VALID=0, ST_FULL=1, ST_OVR=2, ST_FERR=3).
  - FSM state encodings (IDLE, START, DATA, STOP, BRK).
- One natural sub-module: uart_rx_fifo (sync FIFO; push/pop/full/empty, head data). Synchroniser, tick generator and FSM stay in the top.

Test Plan:
- Basic receive (SAMPLE_DIV=1, 16 clk/bit): send 0xA5 with 8N1.
  - -> irq=1 one clk after the stop mid-sample.
  - -> STAT read = 0x01; DATA read = 0xA5.
  - -> then STAT = 0x00, irq=0.
- Glitch rejection: rx low for 4 clk, then high.
  - -> FSM returns to IDLE, FIFO empty, STAT=0x00.
  - -> next clean frame 0x3C received correctly.
- Overrun (FIFO_DEPTH=4): send 0x01..0x05 with no reads.
  - -> STAT=0x06 (full, ovr; valid=1 also gives 0x07).
  - -> reads return 0x01,0x02,0x03,0x04; 0x05 is lost.
  - -> STAT write clears ovr.
- Framing error: send 0x55 with the stop bit low, holding rx low for 40 bit times.
  - -> ferr=1, nothing pushed, no retrigger until rx returns high.
  - -> a following 0x7E is received.
- Full plus simultaneous pop: FIFO holds 4 bytes; the DATA read is timed on the same clk as the 5th byte's push.
  - -> no ovr, occupancy stays 4, 5th byte is retained.
- Async reset mid-frame: assert reset during DATA bit 3.
  - -> FIFO empty, irq=0.
  - -> after release, the next frame 0xC3 is received.
- Empty DATA read -> rd_data=0x00, rd_hit=1, pointers unchanged.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Contains bus addresses, status bit positions and receiver FSM states.
package uart_rx_mmio_pkg;

  localparam logic [10:0] DEF_DATA_ADDR = 11'd102;
  localparam logic [10:0] DEF_STAT_ADDR = 11'd103;

  localparam int ST_VALID = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FERR  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO with a combinational head output.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling, deframing FSM,
// receive FIFO and data/status registers on the CPU data bus.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 13,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [10:0] DATA_ADDR  = DEF_DATA_ADDR,
  parameter logic [10:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [10:0] m_addr,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic        m_en,
  input  logic [7:0]  m_wr_data,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic        irq
);

  rx_state_e  state_q, state_d;
  logic       rx_meta_q, rx_s_q, rx_d1_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       ovr_q, ovr_d, ferr_q, ferr_d;
  logic       tick, fall, push, set_ovr, set_ferr;
  logic       rd_sel, wr_sel, data_hit, stat_hit, pop;
  logic [7:0] head, status;
  logic       full, empty;
  logic       unused_wr_data;

  assign unused_wr_data = ^m_wr_data;

  assign fall = rx_d1_q & ~rx_s_q;
  assign tick = (state_q != S_IDLE) && (cnt_q == 8'(SAMPLE_DIV - 1));

  assign rd_sel   = m_en & m_rd;
  assign wr_sel   = m_en & m_wr;
  assign data_hit = (m_addr == DATA_ADDR);
  assign stat_hit = (m_addr == STAT_ADDR);
  assign rd_hit   = rd_sel & (data_hit | stat_hit);
  assign pop      = rd_sel & data_hit & ~empty;
  assign irq      = ~empty;

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    set_ovr  = 1'b0;
    set_ferr = 1'b0;
    cnt_d    = (state_q == S_IDLE || tick) ? 8'd0 : cnt_q + 8'd1;
    case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_START;
        sc_d    = 4'd0;
      end
      S_START: if (tick) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd7) begin
          sc_d    = 4'd0;
          bit_d   = 3'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: if (tick) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd15) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: if (tick) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd15) begin
          if (rx_s_q) begin
            if (full && !pop) set_ovr = 1'b1;
            else              push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = S_BRK;
          end
        end
      end
      // Holding here until the line idles stops a long break from looking like new start bits.
      S_BRK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr_sel && stat_hit) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (set_ovr)  ovr_d  = 1'b1;
    if (set_ferr) ferr_d = 1'b1;
  end

  always_comb begin
    status           = 8'h00;
    status[ST_VALID] = ~empty;
    status[ST_FULL]  = full;
    status[ST_OVR]   = ovr_q;
    status[ST_FERR]  = ferr_q;
    rd_data          = 8'h00;
    if (rd_sel && data_hit && !empty) rd_data = head;
    else if (rd_sel && stat_hit)      rd_data = status;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d1_q   <= 1'b1;
      cnt_q     <= 8'd0;
      sc_q      <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d1_q   <= rx_s_q;
      cnt_q     <= cnt_d;
      sc_q      <= sc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at SAMPLE_DIV=1 (16 clk per bit), FIFO_DEPTH=4.
module tb_uart_rx_mmio;

  localparam logic [10:0] DA = 11'd102;
  localparam logic [10:0] SA = 11'd103;

  logic        clk = 1'b0;
  logic        reset, rx, m_rd, m_wr, m_en, rd_hit, irq;
  logic [10:0] m_addr;
  logic [7:0]  m_wr_data, rd_data;
  int          checks = 0;
  int          failures = 0;
  logic        irq_hist [16];
  logic [7:0]  push_rd;
  logic [7:0]  d;
  logic        h;

  always #5 clk = ~clk;

  uart_rx_mmio #(.SAMPLE_DIV(1), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .m_addr    (m_addr),
    .m_rd      (m_rd),
    .m_wr      (m_wr),
    .m_en      (m_en),
    .m_wr_data (m_wr_data),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [10:0] a, output logic [7:0] data, output logic hit);
    @(negedge clk);
    m_addr = a; m_en = 1'b1; m_rd = 1'b1;
    #1;
    data = rd_data;
    hit  = rd_hit;
    @(negedge clk);
    m_en = 1'b0; m_rd = 1'b0;
    $display("read  addr=%0d data=%02h hit=%b", a, data, hit);
  endtask

  task automatic read_chk(input string tag, input logic [10:0] a, input logic [7:0] exp);
    logic [7:0] rdv;
    logic       hv;
    bus_read(a, rdv, hv);
    check(tag, rdv, exp);
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [7:0] data);
    @(negedge clk);
    m_addr = a; m_wr_data = data; m_en = 1'b1; m_wr = 1'b1;
    @(negedge clk);
    m_en = 1'b0; m_wr = 1'b0;
    $display("write addr=%0d data=%02h", a, data);
  endtask

  // Stop-bit cycle j is sampled at negedge 145+j after the start edge; j=9 precedes the push edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int hold_bits, input logic pop_at_push);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_val;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      irq_hist[j] = irq;
      if (pop_at_push && j == 9) begin
        m_addr = DA; m_en = 1'b1; m_rd = 1'b1;
        #1;
        push_rd = rd_data;
      end else begin
        m_en = 1'b0; m_rd = 1'b0;
      end
    end
    if (!stop_val) repeat (hold_bits * 16) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    $display("frame data=%02h stop=%b", b, stop_val);
  endtask

  initial begin
    rx = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_en = 1'b0;
    m_addr = 11'd0; m_wr_data = 8'h00; reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_irq", {7'd0, irq}, 8'h00);
    bus_read(SA, d, h);
    check("rst_stat", d, 8'h00);
    check("rst_hit", {7'd0, h}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic receive
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    check("lat_irq_before", {7'd0, irq_hist[9]}, 8'h00);
    check("lat_irq_after", {7'd0, irq_hist[10]}, 8'h01);
    read_chk("basic_stat", SA, 8'h01);
    read_chk("basic_data", DA, 8'hA5);
    read_chk("basic_stat2", SA, 8'h00);
    check("basic_irq", {7'd0, irq}, 8'h00);

    // Glitch rejection
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    $display("glitch 4 clk");
    check("glitch_irq", {7'd0, irq}, 8'h00);
    read_chk("glitch_stat", SA, 8'h00);
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    read_chk("glitch_next", DA, 8'h3C);

    // Empty read and idle bus
    bus_read(DA, d, h);
    check("empty_data", d, 8'h00);
    check("empty_hit", {7'd0, h}, 8'h01);
    read_chk("empty_stat", SA, 8'h00);
    @(negedge clk);
    check("idle_rd_data", rd_data, 8'h00);
    check("idle_rd_hit", {7'd0, rd_hit}, 8'h00);

    // Overrun
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 0, 1'b0);
    read_chk("ovr_stat", SA, 8'h07);
    for (int v = 1; v <= 4; v++) read_chk("ovr_data", DA, 8'(v));
    read_chk("ovr_stat_empty", SA, 8'h04);
    bus_write(SA, 8'hFF);
    read_chk("ovr_cleared", SA, 8'h00);

    // Full FIFO with pop on the push edge
    for (int v = 0; v < 4; v++) send_frame(8'h10 + 8'(v), 1'b1, 0, 1'b0);
    read_chk("full_stat", SA, 8'h03);
    send_frame(8'h14, 1'b1, 0, 1'b1);
    check("simul_pop_data", push_rd, 8'h10);
    read_chk("simul_stat", SA, 8'h03);
    for (int v = 1; v <= 4; v++) read_chk("simul_data", DA, 8'h10 + 8'(v));
    read_chk("simul_stat_empty", SA, 8'h00);

    // Framing error with long break
    send_frame(8'h55, 1'b0, 40, 1'b0);
    read_chk("ferr_stat", SA, 8'h08);
    check("ferr_irq", {7'd0, irq}, 8'h00);
    send_frame(8'h7E, 1'b1, 0, 1'b0);
    read_chk("ferr_next_stat", SA, 8'h09);
    read_chk("ferr_next_data", DA, 8'h7E);
    bus_write(SA, 8'h00);
    read_chk("ferr_cleared", SA, 8'h00);

    // Write to data register is ignored
    send_frame(8'h11, 1'b1, 0, 1'b0);
    bus_write(DA, 8'h99);
    read_chk("wr_data_ignored", SA, 8'h01);
    check("pre_reset_irq", {7'd0, irq}, 8'h01);

    // Async reset during data bit 3
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    $display("reset asserted mid-frame");
    check("rst_mid_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    read_chk("rst_mid_stat", SA, 8'h00);
    send_frame(8'hC3, 1'b1, 0, 1'b0);
    read_chk("rst_next_stat", SA, 8'h01);
    read_chk("rst_next_data", DA, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
